// File: rtl/fp_unit_pkg.sv
// Shared constants and types for the FP execution units and their adapters.
package fp_unit_pkg;

  localparam int FP_SQRT_LATENCY = 28;
  localparam int FP_TAG_W        = 5;
  localparam int FP_DATA_W       = 32;

  typedef struct packed {
    logic [FP_TAG_W-1:0]  tag;
    logic [FP_DATA_W-1:0] data;
  } fp_result_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with modulo pointers and an occupancy counter.
// Same-cycle push and pop are both honoured, including when full.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/fp_sqrt_issue_adapter.sv
// Valid/ready front end for the fixed-latency, non-stallable FPSqrt32 unit.
// Credits bound in-flight work so every done result has a free FIFO slot.
module fp_sqrt_issue_adapter
  import fp_unit_pkg::*;
#(
  parameter int LATENCY = FP_SQRT_LATENCY,
  parameter int DEPTH   = 32,
  parameter int TAG_W   = FP_TAG_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic [TAG_W-1:0] in_tag,
  output logic             unit_go,
  output logic [31:0]      unit_operand,
  input  logic             unit_done,
  input  logic [31:0]      unit_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             err
);

  localparam int CRED_W  = $clog2(DEPTH + 1);
  localparam int GUARD_W = $clog2(LATENCY + 1);

  logic [CRED_W-1:0]  credits_q, credits_d;
  logic [GUARD_W-1:0] guard_q, guard_d;
  logic               unit_go_q, unit_go_d;
  logic [31:0]        unit_operand_q, unit_operand_d;
  logic               err_q, err_d;

  logic             accept, out_hs, done_live, tag_pop;
  logic [TAG_W-1:0] tag_head;
  logic             tag_full, tag_empty, res_full, res_empty;
  logic [TAG_W+31:0] res_head;

  assign in_ready  = (guard_q == '0) && (credits_q != '0);
  assign accept    = in_valid && in_ready;
  assign out_valid = !res_empty;
  assign out_hs    = out_valid && out_ready;
  // The unit is never reset, so done pulses inside the guard window are stale.
  assign done_live = unit_done && (guard_q == '0);
  assign tag_pop   = done_live && !tag_empty;

  always_comb begin
    guard_d        = (guard_q == '0) ? '0 : guard_q - 1'b1;
    unit_go_d      = accept;
    unit_operand_d = accept ? in_data : unit_operand_q;
    credits_d      = credits_q;
    case ({accept, out_hs})
      2'b10:   credits_d = credits_q - 1'b1;
      2'b01:   credits_d = (credits_q == CRED_W'(DEPTH)) ? credits_q : credits_q + 1'b1;
      default: credits_d = credits_q;
    endcase
    err_d = err_q
          | (done_live && tag_empty)
          | (tag_pop && res_full && !out_hs)
          | (accept && tag_full);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      credits_q      <= CRED_W'(DEPTH);
      guard_q        <= GUARD_W'(LATENCY);
      unit_go_q      <= 1'b0;
      unit_operand_q <= '0;
      err_q          <= 1'b0;
    end else begin
      credits_q      <= credits_d;
      guard_q        <= guard_d;
      unit_go_q      <= unit_go_d;
      unit_operand_q <= unit_operand_d;
      err_q          <= err_d;
    end
  end

  assign unit_go      = unit_go_q;
  assign unit_operand = unit_operand_q;
  assign err          = err_q;

  sync_fifo #(.WIDTH(TAG_W), .DEPTH(DEPTH)) u_tag_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (accept),
    .push_data (in_tag),
    .pop       (tag_pop),
    .pop_data  (tag_head),
    .full      (tag_full),
    .empty     (tag_empty)
  );

  sync_fifo #(.WIDTH(TAG_W + 32), .DEPTH(DEPTH)) u_res_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (tag_pop),
    .push_data ({tag_head, unit_result}),
    .pop       (out_hs),
    .pop_data  (res_head),
    .full      (res_full),
    .empty     (res_empty)
  );

  assign {out_tag, out_data} = res_head;

endmodule

// File: tb/tb_fp_sqrt_issue_adapter.sv
// Scoreboard bench for fp_sqrt_issue_adapter with a behavioural FPSqrt32 model.
module tb_fp_sqrt_issue_adapter;
  import fp_unit_pkg::*;

  localparam int LAT   = 28;
  localparam int DEPTH = 32;
  localparam int TW    = 5;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [31:0]   in_data = '0;
  logic [TW-1:0] in_tag = '0;
  logic          unit_go;
  logic [31:0]   unit_operand;
  logic          unit_done = 1'b0;
  logic [31:0]   unit_result = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_data;
  logic [TW-1:0] out_tag;
  logic          err;

  fp_sqrt_issue_adapter #(.LATENCY(LAT), .DEPTH(DEPTH), .TAG_W(TW)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_tag(in_tag),
    .unit_go(unit_go), .unit_operand(unit_operand),
    .unit_done(unit_done), .unit_result(unit_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
    .err(err)
  );

  always #5 clock = ~clock;

  typedef struct { int due; logic [31:0] res; } unit_ev_t;

  int tests = 0;
  int fails = 0;
  fp_result_t exp_q[$];
  unit_ev_t   uq[$];
  int ncnt = 0, since_rst = 0, outstanding = 0, acc_cnt = 0;
  bit prev_acc = 0, err_exp = 0, err_next = 0, spur_req = 0;

  // Stand-in for the square-root unit: exact for the known vector, a fixed scramble otherwise.
  function automatic logic [31:0] unit_fn(input logic [31:0] x);
    if (x == 32'h4080_0000) return 32'h4000_0000;
    return {x[15:0], x[31:16]} ^ 32'h3c5a_96e1;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor, scoreboard and unit model, all sampled mid-cycle.
  always @(negedge clock) begin
    bit acc, hs;
    ncnt++;
    err_exp  = err_exp | err_next;
    err_next = 0;
    if (reset) begin
      outstanding = 0;
      exp_q.delete();
      prev_acc = 0;
      err_exp  = 0;
      check("reset_out_valid", out_valid, 0);
      check("reset_out_data", out_data, 0);
      check("reset_out_tag", out_tag, 0);
      check("reset_operand", unit_operand, 0);
    end
    check("in_ready", in_ready, !reset && since_rst >= LAT && outstanding < DEPTH);
    check("unit_go", unit_go, !reset && prev_acc);
    check("err", err, err_exp);
    if (out_valid) begin
      if (exp_q.size() == 0) check("unexpected_out_valid", out_valid, 0);
      else begin
        check("out_data", out_data, exp_q[0].data);
        check("out_tag", out_tag, exp_q[0].tag);
      end
    end
    acc = in_valid && in_ready && !reset;
    hs  = out_valid && out_ready && !reset;
    if (hs) begin
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      outstanding--;
    end
    if (acc) begin
      exp_q.push_back('{tag: in_tag, data: unit_fn(in_data)});
      outstanding++;
      acc_cnt++;
    end
    prev_acc  = acc;
    since_rst = reset ? 0 : since_rst + 1;
    // unit: go seen now is sampled at the next edge; done must be sampled LAT edges after that
    if (unit_go === 1'b1) uq.push_back('{ncnt + 1 + LAT, unit_fn(unit_operand)});
    unit_done   = 1'b0;
    unit_result = $urandom;
    if (uq.size() != 0 && uq[0].due == ncnt + 1) begin
      unit_done   = 1'b1;
      unit_result = uq[0].res;
      void'(uq.pop_front());
    end else if (spur_req) begin
      unit_done = 1'b1;
      spur_req  = 0;
      if (!reset && since_rst > LAT) err_next = 1;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drain(input int lim);
    int n = 0;
    while ((exp_q.size() != 0 || uq.size() != 0) && n < lim) begin
      step();
      n++;
    end
    check("drain_exp_q_empty", exp_q.size(), 0);
    check("drain_outstanding", outstanding, 0);
  endtask

  initial begin
    int n, a0;
    #1 reset = 1'b1;
    step(); step();
    reset = 1'b0;

    // guard: in_ready stays low for LAT cycles after release
    n = 0;
    while (!in_ready && n < 100) begin step(); n++; end
    check("guard_cycles", n, LAT);

    // single operation and latency: valid visible after edge t+29, sampled high at t+30
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 32'h4080_0000; in_tag = 5'd3;
    step();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin step(); n++; end
    check("single_latency", n, LAT + 1);
    check("single_data", out_data, 32'h4000_0000);
    check("single_tag", out_tag, 3);
    step(); step();
    check("single_ready_after", in_ready, 1);

    // streaming: 100 back-to-back accepts with tags wrapping mod 32
    a0 = acc_cnt;
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_data = $urandom;
      in_tag  = TW'(i % 32);
      check("stream_no_bubble", in_ready, 1);
      step();
    end
    in_valid = 1'b0;
    check("stream_accepts", acc_cnt - a0, 100);
    drain(200);

    // back-pressure: exactly DEPTH accepts, then one per single handshake
    out_ready = 1'b0;
    in_valid  = 1'b1;
    a0 = acc_cnt;
    for (int i = 0; i < 70; i++) begin
      in_data = $urandom; in_tag = TW'($urandom);
      step();
    end
    check("bp_accepts", acc_cnt - a0, DEPTH);
    check("bp_ready_low", in_ready, 0);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    repeat (10) step();
    check("bp_one_more", acc_cnt - a0, DEPTH + 1);
    check("bp_ready_low2", in_ready, 0);
    // two handshakes: second coincides with an accept, third cycle accepts alone
    out_ready = 1'b1; step(); step(); out_ready = 1'b0;
    repeat (10) step();
    check("bp_simultaneous", acc_cnt - a0, DEPTH + 3);
    in_valid = 1'b0; out_ready = 1'b1;
    drain(300);

    // reset mid-flight: stale done pulses land inside the guard window
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = $urandom; in_tag = TW'(i);
      step();
    end
    in_valid = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    n = 0;
    while (!in_ready && n < 100) begin step(); n++; end
    check("reset_guard_cycles", n, LAT);
    check("reset_no_err", err, 0);
    check("reset_unit_idle", uq.size(), 0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_data   = $urandom;
      in_tag    = TW'($urandom);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    drain(300);

    // spurious done with nothing pending
    spur_req = 1;
    step();
    for (int i = 0; i < 10; i++) begin
      step();
      check("spur_no_out_valid", out_valid, 0);
    end
    check("spur_err_sticky", err, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
